// File: rtl/add_sub_serial.sv
// ============================================================================
// Module   : add_sub_serial
// Brief    : Digit-serial two's-complement adder/subtractor, DIGIT bits/clock.
//            Optional saturation on overflow with ADD_SUB_SERIAL_SAT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module add_sub_serial #(
    parameter int WIDTH = 6,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int c_n  = WIDTH / DIGIT;
    localparam int c_kw = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_kw-1:0] c_last = c_kw'(c_n - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic [c_kw-1:0]  r_k;
    logic [WIDTH-1:0] r_acc;

    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_sum_final;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result;

    // r_b already holds the inverted operand for subtraction
    always_comb begin
        w_da        = r_a[r_k*DIGIT +: DIGIT];
        w_db        = r_b[r_k*DIGIT +: DIGIT];
        w_dsum      = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_c};
        w_sum_final = r_acc;
        w_sum_final[r_k*DIGIT +: DIGIT] = w_dsum[DIGIT-1:0];
        // Same-sign operands producing an opposite-sign sum: carry into MSB != carry out
        w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_final[WIDTH-1] != r_a[WIDTH-1]);
    end

`ifdef ADD_SUB_SERIAL_SAT_EN
    always_comb begin
        w_result = w_sum_final;
        if (w_ovf) begin
            w_result = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_result = w_sum_final;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= 1'b0;
            r_k       <= '0;
            r_acc     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= sub ? ~b : b;
                        r_c      <= sub;
                        r_k      <= '0;
                        r_acc    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc <= w_sum_final;
                    r_c   <= w_dsum[DIGIT];
                    r_k   <= r_k + 1'b1;
                    if (r_k == c_last) begin
                        sum       <= w_result;
                        carry     <= w_dsum[DIGIT];
                        overflow  <= w_ovf;
                        zero      <= (w_result == '0);
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_add_sub_serial.sv
// ============================================================================
// Module   : tb_add_sub_serial
// Brief    : Directed vector bench for add_sub_serial (WIDTH=6, DIGIT=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_add_sub_serial;

    localparam int WIDTH = 6;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;
`ifdef ADD_SUB_SERIAL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;
    logic             zero;

    int checks = 0;
    int errors = 0;

    add_sub_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] va;
        logic [5:0] vb;
        logic       vsub;
        logic [5:0] s_wrap;
        logic [5:0] s_sat;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Whole-word signed reference, independent of any digit slicing
    task automatic model(input logic [5:0] ma, input logic [5:0] mb, input logic ms,
                         output logic [5:0] es, output logic ec, output logic ev,
                         output logic ez);
        int sa, sb, sr, ua, ub;
        sa = $signed(ma);
        sb = $signed(mb);
        ua = int'(ma);
        ub = int'(mb);
        sr = ms ? sa - sb : sa + sb;
        ev = (sr > 31) || (sr < -32);
        ec = ms ? (ua >= ub) : ((ua + ub) > 63);
        es = 6'(sr);
        if (SAT && ev) es = (sa >= 0) ? 6'd31 : 6'd32;
        ez = (es == 6'd0);
    endtask

    task automatic start_op(input logic [5:0] ta, input logic [5:0] tb_v, input logic ts);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("accept_ready", int'(in_ready), 1);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        sub = ts;
        @(negedge clk);
        in_valid = 1'b0;
        a = 6'($urandom);
        b = 6'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, int'(out_valid), 0);
        chk({tag, "_release_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int lat;
        logic [5:0] es;
        logic ec, ev, ez;
        logic [5:0] opa [4];
        logic [5:0] opb [4];
        logic       ops [4];
        logic [5:0] pa, pb;
        logic       ps;
        int idx, got, last, cyc;

        tbl[0]  = '{6'd25, 6'd17, 1'b0, 6'd42, 6'd31, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{6'd63, 6'd1,  1'b0, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1};
        tbl[2]  = '{6'd5,  6'd9,  1'b1, 6'd60, 6'd60, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{6'd32, 6'd1,  1'b1, 6'd31, 6'd32, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{6'd10, 6'd10, 1'b1, 6'd0,  6'd0,  1'b1, 1'b0, 1'b1};
        tbl[5]  = '{6'd0,  6'd0,  1'b0, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1};
        tbl[6]  = '{6'd31, 6'd1,  1'b0, 6'd32, 6'd31, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{6'd48, 6'd48, 1'b0, 6'd32, 6'd32, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{6'd40, 6'd20, 1'b0, 6'd60, 6'd60, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{6'd0,  6'd1,  1'b1, 6'd63, 6'd63, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{6'd33, 6'd2,  1'b1, 6'd31, 6'd32, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_carry", int'(carry), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_zero", int'(zero), 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            start_op(tbl[i].va, tbl[i].vb, tbl[i].vsub);
            wait_done(lat);
            chk($sformatf("vec%0d_latency", i), lat, NDIG);
            chk($sformatf("vec%0d_sum", i), int'(sum), int'(SAT ? tbl[i].s_sat : tbl[i].s_wrap));
            chk($sformatf("vec%0d_carry", i), int'(carry), int'(tbl[i].c));
            chk($sformatf("vec%0d_overflow", i), int'(overflow), int'(tbl[i].v));
            chk($sformatf("vec%0d_zero", i), int'(zero), int'(tbl[i].z));
            finish_op($sformatf("vec%0d", i));
        end

        // Backpressure: result held while new requests are offered
        start_op(6'd25, 6'd17, 1'b0);
        wait_done(lat);
        chk("bp_latency", lat, NDIG);
        in_valid = 1'b1;
        a = 6'd1;
        b = 6'd1;
        sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("bp%0d_in_ready", i), int'(in_ready), 0);
            chk($sformatf("bp%0d_sum", i), int'(sum), SAT ? 31 : 42);
            chk($sformatf("bp%0d_flags", i), int'({carry, overflow, zero}), 3'b010);
        end
        in_valid = 1'b0;
        finish_op("bp");
        @(negedge clk);
        chk("bp_no_stray_accept", int'(in_ready), 1);

        // Reset during the second BUSY cycle
        start_op(6'd25, 6'd17, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_outputs", int'({sum, carry, overflow, zero}), 0);
        repeat (4) @(negedge clk);
        chk("mid_rst_no_result", int'(out_valid), 0);
        start_op(6'd1, 6'd2, 1'b0);
        wait_done(lat);
        chk("post_rst_latency", lat, NDIG);
        chk("post_rst_sum", int'(sum), 3);
        finish_op("post_rst");

        // Back-to-back with in_valid and out_ready held high
        for (int i = 0; i < 4; i++) begin
            opa[i] = 6'($urandom);
            opb[i] = 6'($urandom);
            ops[i] = 1'($urandom);
        end
        pa = '0;
        pb = '0;
        ps = 1'b0;
        idx = 0;
        got = 0;
        last = -1;
        cyc = 0;
        out_ready = 1'b1;
        while (got < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                model(pa, pb, ps, es, ec, ev, ez);
                chk($sformatf("b2b%0d_sum", got), int'(sum), int'(es));
                chk($sformatf("b2b%0d_flags", got), int'({carry, overflow, zero}),
                    int'({ec, ev, ez}));
                got++;
            end
            in_valid = (idx < 4);
            if (idx < 4) begin
                a = opa[idx];
                b = opb[idx];
                sub = ops[idx];
                if (in_ready) begin
                    // N BUSY edges, one DONE edge, then IDLE accepts again
                    if (last >= 0) chk($sformatf("b2b%0d_interval", idx), cyc - last, NDIG + 2);
                    last = cyc;
                    pa = opa[idx];
                    pb = opb[idx];
                    ps = ops[idx];
                    idx++;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_results", got, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
